mips_reg_file: RTL and testbench

- 32-entry general-purpose register file for the MIPS CPU.
- Sits directly downstream of the 5-bit destination-register select mux (rt/rd choice). Its write address is that mux's output.
- Two combinational read ports (rs, rt) feed the ALU operand path. One synchronous write port is driven from writeback.
- Register $0 is hardwired to zero. Same-cycle write-to-read bypass is provided, so writeback and decode can overlap in one cycle.

---
 rtl/mips_pkg.sv | 13 +
 rtl/mips_reg_read_port.sv | 43 ++++
 rtl/mips_reg_file.sv | 94 +++++++++
 tb/tb_mips_reg_file.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS widths, register-number constants and word types
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_DATA_W-1:0] word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;
    localparam reg_addr_t REG_RA   = 5'd31;

endpackage

// File: rtl/mips_reg_read_port.sv
// rtl/mips_reg_read_port.sv - one combinational register-file read path
//
// Resolves one read address against the register contents.
// Address 0 always reads 0.
// With BYPASS_EN set, a write pending this cycle to the same address is forwarded.
// Otherwise the stored entry is returned.
// Ports:
//   rst_n     - active-low reset; forces the output to 0 while low
//   addr      - read address
//   wr_en     - write enable of the write port
//   wr_addr   - write address of the write port
//   wr_data   - write data of the write port
//   regs      - flattened register contents, entry 0 reads as zero
//   data      - resolved read value
module mips_reg_read_port
    import mips_pkg::*;
#(
    parameter int DATA_W    = REG_DATA_W,
    parameter int ADDR_W    = REG_ADDR_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic                                  rst_n,
    input  logic [ADDR_W-1:0]                     addr,
    input  logic                                  wr_en,
    input  logic [ADDR_W-1:0]                     wr_addr,
    input  logic [DATA_W-1:0]                     wr_data,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    regs,
    output logic [DATA_W-1:0]                     data
);

    always_comb begin
        data = '0;
        // Reset gating keeps the bypass from leaking writeData while the array is held clear.
        if (rst_n && addr != ADDR_W'(REG_ZERO)) begin
            if (BYPASS_EN && wr_en && wr_addr == addr) begin
                data = wr_data;
            end else begin
                data = regs[addr];
            end
        end
    end

endmodule

// File: rtl/mips_reg_file.sv
// rtl/mips_reg_file.sv - 32-entry MIPS register file, two read ports, one write port
//
// Register $0 is hardwired to zero.
// Reads are combinational.
// Writes happen on the rising clock edge.
// writeCount counts committed writes and wraps at 16 bits.
// Ports:
//   clk, rst_n             - clock; asynchronous active-low reset
//   regWrite               - write enable
//   writeReg, writeData    - write address and data
//   readReg1/2, readData1/2 - rs/rt read ports
//   dbgAddr, dbgData       - stored-content observation port, never bypassed
//   writeCount             - committed writes since reset
module mips_reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W    = REG_DATA_W,
    parameter int ADDR_W    = REG_ADDR_W,
    parameter bit BYPASS_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] writeReg,
    input  logic [DATA_W-1:0] writeData,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic [DATA_W-1:0] readData1,
    output logic [DATA_W-1:0] readData2,
    input  logic [ADDR_W-1:0] dbgAddr,
    output logic [DATA_W-1:0] dbgData,
    output logic [15:0]       writeCount
);

    localparam int NUM_REGS = 2**ADDR_W;

    // Entry 0 has no storage; the array starts at 1.
    logic [DATA_W-1:0]                  mem [1:NUM_REGS-1];
    logic [NUM_REGS-1:0][DATA_W-1:0]    regs;
    logic                               commit;

    assign commit = regWrite && (writeReg != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                mem[i] <= '0;
            end
            writeCount <= '0;
        end else if (commit) begin
            mem[writeReg] <= writeData;
            writeCount    <= writeCount + 16'd1;
        end
    end

    always_comb begin
        regs = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            regs[i] = mem[i];
        end
    end

    mips_reg_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_rd1 (
        .rst_n   (rst_n),
        .addr    (readReg1),
        .wr_en   (regWrite),
        .wr_addr (writeReg),
        .wr_data (writeData),
        .regs    (regs),
        .data    (readData1)
    );

    mips_reg_read_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BYPASS_EN (BYPASS_EN)
    ) u_rd2 (
        .rst_n   (rst_n),
        .addr    (readReg2),
        .wr_en   (regWrite),
        .wr_addr (writeReg),
        .wr_data (writeData),
        .regs    (regs),
        .data    (readData2)
    );

    // Entry 0 of regs is constant zero, so no separate zero check is needed here.
    assign dbgData = regs[dbgAddr];

endmodule

// File: tb/tb_mips_reg_file.sv
// tb/tb_mips_reg_file.sv - directed self-checking bench for mips_reg_file
module tb_mips_reg_file;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        regWrite = 1'b0;
    logic [4:0]  writeReg = '0;
    logic [31:0] writeData = '0;
    logic [4:0]  readReg1 = '0;
    logic [4:0]  readReg2 = '0;
    logic [4:0]  dbgAddr = '0;

    logic [31:0] b_rd1, b_rd2, b_dbg;
    logic [15:0] b_cnt;
    logic [31:0] n_rd1, n_rd2, n_dbg;
    logic [15:0] n_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mips_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .writeReg(writeReg),
        .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(b_rd1), .readData2(b_rd2), .dbgAddr(dbgAddr),
        .dbgData(b_dbg), .writeCount(b_cnt)
    );

    mips_reg_file #(.DATA_W(32), .ADDR_W(5), .BYPASS_EN(1'b0)) u_nob (
        .clk(clk), .rst_n(rst_n), .regWrite(regWrite), .writeReg(writeReg),
        .writeData(writeData), .readReg1(readReg1), .readReg2(readReg2),
        .readData1(n_rd1), .readData2(n_rd2), .dbgAddr(dbgAddr),
        .dbgData(n_dbg), .writeCount(n_cnt)
    );

    always @(posedge clk) begin
        assert (!$isunknown(regWrite)) else $error("regWrite is unknown");
    end

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        regWrite  = 1'b1;
        writeReg  = a;
        writeData = d;
        @(posedge clk);
        #1;
        regWrite  = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        total++; if (b_rd1 !== 32'h0 || b_rd2 !== 32'h0 || b_dbg !== 32'h0) begin
            bad++; $display("FAIL reset_init_byp got=%h/%h/%h exp=0", b_rd1, b_rd2, b_dbg); end
        total++; if (b_cnt !== 16'h0 || n_cnt !== 16'h0) begin
            bad++; $display("FAIL reset_init_cnt got=%h/%h exp=0", b_cnt, n_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        // Load values, then reset mid-cycle and observe immediately.
        do_write(5'd5, 32'hA5A5_0005);
        do_write(5'd6, 32'hA5A5_0006);
        @(negedge clk);
        readReg1 = 5'd5; readReg2 = 5'd6; dbgAddr = 5'd6;
        #1;
        total++; if (b_rd1 !== 32'hA5A5_0005 || b_dbg !== 32'hA5A5_0006) begin
            bad++; $display("FAIL reset_preload got=%h/%h exp=a5a50005/a5a50006", b_rd1, b_dbg); end
        #1;
        rst_n = 1'b0;
        #1;
        total++; if (b_rd1 !== 32'h0 || b_rd2 !== 32'h0 || b_dbg !== 32'h0 || n_rd1 !== 32'h0) begin
            bad++; $display("FAIL reset_async_data got=%h/%h/%h/%h exp=0", b_rd1, b_rd2, b_dbg, n_rd1); end
        total++; if (b_cnt !== 16'h0 || n_cnt !== 16'h0) begin
            bad++; $display("FAIL reset_async_cnt got=%h/%h exp=0", b_cnt, n_cnt); end
        // Write attempted while reset is held: reset wins, bypass is suppressed.
        regWrite = 1'b1; writeReg = 5'd7; writeData = 32'hCAFE_0007;
        readReg1 = 5'd7; dbgAddr = 5'd7;
        #1;
        total++; if (b_rd1 !== 32'h0) begin
            bad++; $display("FAIL reset_bypass_blocked got=%h exp=0", b_rd1); end
        @(posedge clk);
        #1;
        total++; if (b_dbg !== 32'h0 || b_cnt !== 16'h0) begin
            bad++; $display("FAIL reset_wins got=%h/%h exp=0/0", b_dbg, b_cnt); end
        regWrite = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        do_write(5'd8, 32'hDEAD_BEEF);
        readReg1 = 5'd8; readReg2 = 5'd8;
        #1;
        total++; if (b_rd1 !== 32'hDEAD_BEEF || b_rd2 !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL basic_byp got=%h/%h exp=deadbeef", b_rd1, b_rd2); end
        total++; if (n_rd1 !== 32'hDEAD_BEEF || n_rd2 !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL basic_nob got=%h/%h exp=deadbeef", n_rd1, n_rd2); end
        total++; if (b_cnt !== 16'd1) begin
            bad++; $display("FAIL basic_cnt got=%h exp=0001", b_cnt); end
    endtask

    task automatic test_zero_reg;
        @(negedge clk);
        regWrite = 1'b1; writeReg = 5'd0; writeData = 32'h1234_5678;
        readReg1 = 5'd0; dbgAddr = 5'd0;
        #1;
        total++; if (b_rd1 !== 32'h0) begin
            bad++; $display("FAIL zero_no_bypass got=%h exp=0", b_rd1); end
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        #1;
        total++; if (b_rd1 !== 32'h0 || b_dbg !== 32'h0 || n_dbg !== 32'h0) begin
            bad++; $display("FAIL zero_read got=%h/%h/%h exp=0", b_rd1, b_dbg, n_dbg); end
        total++; if (b_cnt !== 16'd1 || n_cnt !== 16'd1) begin
            bad++; $display("FAIL zero_cnt got=%h/%h exp=0001", b_cnt, n_cnt); end
    endtask

    task automatic test_bypass;
        do_write(5'd9, 32'h0000_0001);
        @(negedge clk);
        regWrite = 1'b1; writeReg = 5'd9; writeData = 32'h55AA_55AA;
        readReg1 = 5'd3; readReg2 = 5'd9; dbgAddr = 5'd9;
        #1;
        total++; if (b_rd2 !== 32'h55AA_55AA) begin
            bad++; $display("FAIL bypass_rd2 got=%h exp=55aa55aa", b_rd2); end
        total++; if (b_rd1 !== 32'h0) begin
            bad++; $display("FAIL bypass_rd1_indep got=%h exp=0", b_rd1); end
        total++; if (b_dbg !== 32'h1 || n_dbg !== 32'h1) begin
            bad++; $display("FAIL bypass_dbg_before got=%h/%h exp=1", b_dbg, n_dbg); end
        total++; if (n_rd2 !== 32'h1) begin
            bad++; $display("FAIL nobypass_old got=%h exp=1", n_rd2); end
        @(posedge clk);
        #1;
        regWrite = 1'b0;
        #1;
        total++; if (b_rd2 !== 32'h55AA_55AA || n_rd2 !== 32'h55AA_55AA) begin
            bad++; $display("FAIL bypass_after got=%h/%h exp=55aa55aa", b_rd2, n_rd2); end
        total++; if (b_dbg !== 32'h55AA_55AA) begin
            bad++; $display("FAIL bypass_dbg_after got=%h exp=55aa55aa", b_dbg); end
        total++; if (b_cnt !== 16'd3) begin
            bad++; $display("FAIL bypass_cnt got=%h exp=0003", b_cnt); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vals [3];
        vals[0] = 32'h1111_0004; vals[1] = 32'h2222_0004; vals[2] = 32'h3333_0004;
        readReg1 = 5'd4;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            regWrite = 1'b1; writeReg = 5'd4; writeData = vals[k];
            #1;
            total++; if (b_rd1 !== vals[k]) begin
                bad++; $display("FAIL b2b_bypass[%0d] got=%h exp=%h", k, b_rd1, vals[k]); end
            if (k > 0) begin
                total++; if (n_rd1 !== vals[k-1]) begin
                    bad++; $display("FAIL b2b_old[%0d] got=%h exp=%h", k, n_rd1, vals[k-1]); end
            end
        end
        @(negedge clk);
        regWrite = 1'b0;
        #1;
        total++; if (n_rd1 !== 32'h3333_0004 || b_cnt !== 16'd6) begin
            bad++; $display("FAIL b2b_final got=%h/%h exp=33330004/0006", n_rd1, b_cnt); end
    endtask

    task automatic test_sweep;
        logic [31:0] e1, e2;
        for (int i = 1; i < 32; i++) begin
            do_write(5'(i), 32'(i) * 32'h0101_0101);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            readReg1 = 5'(i); readReg2 = 5'(31 - i); dbgAddr = 5'(i);
            e1 = 32'(i) * 32'h0101_0101;
            e2 = 32'(31 - i) * 32'h0101_0101;
            #1;
            total++; if (b_rd1 !== e1 || b_rd2 !== e2 || b_dbg !== e1) begin
                bad++; $display("FAIL sweep_byp[%0d] got=%h/%h/%h exp=%h/%h/%h",
                                i, b_rd1, b_rd2, b_dbg, e1, e2, e1); end
            total++; if (n_rd1 !== e1 || n_rd2 !== e2 || n_dbg !== e1) begin
                bad++; $display("FAIL sweep_nob[%0d] got=%h/%h/%h exp=%h/%h/%h",
                                i, n_rd1, n_rd2, n_dbg, e1, e2, e1); end
        end
        total++; if (b_cnt !== 16'd37) begin
            bad++; $display("FAIL sweep_cnt got=%h exp=0025", b_cnt); end
    endtask

    task automatic test_wrap;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (b_cnt !== 16'h0) begin
            bad++; $display("FAIL wrap_start got=%h exp=0000", b_cnt); end
        @(negedge clk);
        regWrite = 1'b1; writeReg = 5'd1; writeData = 32'h0BAD_F00D;
        repeat (65535) @(posedge clk);
        @(negedge clk);
        regWrite = 1'b0;
        #1;
        total++; if (b_cnt !== 16'hFFFF || n_cnt !== 16'hFFFF) begin
            bad++; $display("FAIL wrap_ffff got=%h/%h exp=ffff", b_cnt, n_cnt); end
        do_write(5'd2, 32'h0000_0002);
        total++; if (b_cnt !== 16'h0000 || n_cnt !== 16'h0000) begin
            bad++; $display("FAIL wrap_zero got=%h/%h exp=0000", b_cnt, n_cnt); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_zero_reg;
        test_bypass;
        test_back_to_back;
        test_sweep;
        test_wrap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
